// File: rtl/cfg_frame_pkg.sv
// ---------------------------------------------------------------------------
// cfg_frame_pkg
// Shared constants and types for the configuration frame writer:
//   - SYNC_WORD / DESYNC_WORD stream markers
//   - bit positions of the frame and column fields inside a header word
//   - the parser state enum
//   - small helpers that pull the header fields out of a stream word
// ---------------------------------------------------------------------------
package cfg_frame_pkg;

    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

    localparam int HDR_FRAME_MSB = 31;
    localparam int HDR_FRAME_LSB = 24;
    localparam int HDR_COL_MSB   = 23;
    localparam int HDR_COL_LSB   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        STROBE = 2'd3
    } cfg_state_e;

    function automatic logic [7:0] hdr_frame(input logic [31:0] word);
        return word[HDR_FRAME_MSB:HDR_FRAME_LSB];
    endfunction

    function automatic logic [7:0] hdr_col(input logic [31:0] word);
        return word[HDR_COL_MSB:HDR_COL_LSB];
    endfunction

endpackage

// File: rtl/config_frame_writer_if.sv
// ---------------------------------------------------------------------------
// config_frame_writer_if
// Valid/ready word stream feeding the configuration frame writer.
//   in_data  : 32-bit stream word        (master -> slave)
//   in_valid : in_data holds a word      (master -> slave)
//   in_ready : slave accepts this cycle  (slave  -> master)
// A word transfers on a rising edge where in_valid && in_ready.
// ---------------------------------------------------------------------------
interface config_frame_writer_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/frame_strobe_decoder.sv
// ---------------------------------------------------------------------------
// frame_strobe_decoder
// Combinational one-hot decoder for the column frame strobes. Bit
// col*MaxFramesPerCol+frame is set when enable_i is high; all bits are zero
// otherwise. The parent registers the result.
//   enable_i : fire a strobe this cycle
//   frame_i  : frame index within the column
//   col_i    : column index
//   strobe_o : one-hot strobe vector, NumberOfCols*MaxFramesPerCol wide
// ---------------------------------------------------------------------------
module frame_strobe_decoder #(
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfCols    = 16
) (
    input  logic                                    enable_i,
    input  logic [7:0]                              frame_i,
    input  logic [7:0]                              col_i,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] strobe_o
);

    // Each bit compares against its own constant (col, frame) pair, which
    // avoids building a wide multiply for the flat index.
    for (genvar gi = 0; gi < NumberOfCols*MaxFramesPerCol; gi++) begin : g_bit
        localparam logic [7:0] BitCol   = 8'(gi / MaxFramesPerCol);
        localparam logic [7:0] BitFrame = 8'(gi % MaxFramesPerCol);
        assign strobe_o[gi] = enable_i && (col_i == BitCol) && (frame_i == BitFrame);
    end

endmodule

// File: rtl/config_frame_writer.sv
// ---------------------------------------------------------------------------
// config_frame_writer
// Configuration-port master. Parses a SYNC / header / data word stream,
// assembles one column-slice of frame data (row 0 = first data word) and
// then pulses exactly one FrameStrobe bit for one cycle.
//
// Ports:
//   UserCLK     : clock
//   resetn      : synchronous active-low reset
//   s_if        : config_frame_writer_if.slave word stream (in_data,
//                 in_valid, in_ready)
//   FrameData   : assembled frame, row r at bits [32r+31:32r]
//   FrameStrobe : one-hot strobe, bit col*MaxFramesPerCol+frame
//   busy        : state is not IDLE
//   error       : sticky; set by a bad header (or checksum mismatch),
//                 cleared by reset or SYNC accepted in IDLE
//   frames_done : strobes issued, wraps at 16 bits
//
// Build option: define CFG_CHECKSUM_EN to require one extra word after the
// rows holding the XOR of all data words; a mismatch suppresses the strobe,
// sets error and returns to IDLE.
// ---------------------------------------------------------------------------
module config_frame_writer
    import cfg_frame_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumberOfRows    = 16,
    parameter int NumberOfCols    = 16
) (
    input  logic                                    UserCLK,
    input  logic                                    resetn,
    config_frame_writer_if.slave                    s_if,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                    busy,
    output logic                                    error,
    output logic [15:0]                             frames_done
);

    localparam int FdW      = NumberOfRows * FrameBitsPerRow;
    localparam int StrW     = NumberOfCols * MaxFramesPerCol;
    localparam int RowCntW  = $clog2(NumberOfRows + 1);
    localparam logic [7:0] MaxFrame8 = 8'(MaxFramesPerCol);
    localparam logic [7:0] MaxCol8   = 8'(NumberOfCols);
    localparam logic [RowCntW-1:0] LastRow = RowCntW'(NumberOfRows - 1);

    cfg_state_e         state_q, state_d;
    logic [RowCntW-1:0] row_cnt_q, row_cnt_d;
    logic [7:0]         frame_q, frame_d;
    logic [7:0]         col_q, col_d;
    logic [FdW-1:0]     frame_data_q, frame_data_d;
    logic [StrW-1:0]    strobe_q, strobe_d;
    logic               error_q, error_d;
    logic [15:0]        frames_done_q, frames_done_d;
    logic               fire_strobe;
    logic               accept;
    logic [7:0]         in_frame;
    logic [7:0]         in_col;
    logic               hdr_bad;
`ifdef CFG_CHECKSUM_EN
    localparam logic [RowCntW-1:0] CkRow = RowCntW'(NumberOfRows);
    logic [31:0]        xor_q, xor_d;
`endif

    // Handshake outputs are a pure decode of the state register.
    assign s_if.in_ready = (state_q != STROBE);
    assign busy          = (state_q != IDLE);
    assign accept        = s_if.in_valid && s_if.in_ready;

    assign in_frame = hdr_frame(s_if.in_data);
    assign in_col   = hdr_col(s_if.in_data);
    assign hdr_bad  = (in_frame >= MaxFrame8) || (in_col >= MaxCol8);

    assign FrameData   = frame_data_q;
    assign FrameStrobe = strobe_q;
    assign error       = error_q;
    assign frames_done = frames_done_q;

    // The strobe is decoded from the latched address on the cycle the last
    // word is accepted, so it registers on that same edge.
    frame_strobe_decoder #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .NumberOfCols    (NumberOfCols)
    ) u_decoder (
        .enable_i (fire_strobe),
        .frame_i  (frame_q),
        .col_i    (col_q),
        .strobe_o (strobe_d)
    );

    always_comb begin
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        frame_d       = frame_q;
        col_d         = col_q;
        frame_data_d  = frame_data_q;
        error_d       = error_q;
        frames_done_d = frames_done_q;
        fire_strobe   = 1'b0;
`ifdef CFG_CHECKSUM_EN
        xor_d         = xor_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept && s_if.in_data == SYNC_WORD) begin
                    error_d = 1'b0;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (accept) begin
                    if (s_if.in_data == SYNC_WORD) begin
                        state_d = HEADER;
                    end else if (s_if.in_data == DESYNC_WORD) begin
                        state_d = IDLE;
                    end else if (hdr_bad) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_d   = in_frame;
                        col_d     = in_col;
                        row_cnt_d = '0;
`ifdef CFG_CHECKSUM_EN
                        xor_d     = '0;
`endif
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
`ifdef CFG_CHECKSUM_EN
                    if (row_cnt_q == CkRow) begin
                        // Checksum word: not shifted into FrameData.
                        if (s_if.in_data == xor_q) begin
                            fire_strobe = 1'b1;
                            state_d     = STROBE;
                        end else begin
                            error_d = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        frame_data_d = {s_if.in_data, frame_data_q[FdW-1:FrameBitsPerRow]};
                        xor_d        = xor_q ^ s_if.in_data;
                        row_cnt_d    = row_cnt_q + RowCntW'(1);
                    end
`else
                    // Shift down so the first word ends up in row 0.
                    frame_data_d = {s_if.in_data, frame_data_q[FdW-1:FrameBitsPerRow]};
                    row_cnt_d    = row_cnt_q + RowCntW'(1);
                    if (row_cnt_q == LastRow) begin
                        fire_strobe = 1'b1;
                        state_d     = STROBE;
                    end
`endif
                end
            end
            STROBE: begin
                frames_done_d = frames_done_q + 16'd1;
                state_d       = HEADER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge UserCLK) begin
        if (!resetn) begin
            state_q       <= IDLE;
            row_cnt_q     <= '0;
            frame_q       <= '0;
            col_q         <= '0;
            frame_data_q  <= '0;
            strobe_q      <= '0;
            error_q       <= 1'b0;
            frames_done_q <= '0;
`ifdef CFG_CHECKSUM_EN
            xor_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            frame_q       <= frame_d;
            col_q         <= col_d;
            frame_data_q  <= frame_data_d;
            strobe_q      <= strobe_d;
            error_q       <= error_d;
            frames_done_q <= frames_done_d;
`ifdef CFG_CHECKSUM_EN
            xor_q         <= xor_d;
`endif
        end
    end

endmodule

// File: tb/tb_config_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_config_frame_writer
// Self-checking bench for config_frame_writer. Frames are built from random
// addresses and data; expected FrameData / strobe index / counters come from
// the frame contents directly. A negedge monitor records every strobe.
// Honours CFG_CHECKSUM_EN when the design is built with it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_config_frame_writer;
    import cfg_frame_pkg::*;

    localparam int ROWS = 16;
    localparam int FPC  = 20;
    localparam int COLS = 16;
    localparam int STRW = FPC * COLS;
    localparam int FDW  = ROWS * 32;

    logic             UserCLK = 1'b0;
    logic             resetn  = 1'b0;
    logic [FDW-1:0]   FrameData;
    logic [STRW-1:0]  FrameStrobe;
    logic             busy;
    logic             error;
    logic [15:0]      frames_done;

    config_frame_writer_if sif();

    config_frame_writer #(
        .MaxFramesPerCol (FPC),
        .FrameBitsPerRow (32),
        .NumberOfRows    (ROWS),
        .NumberOfCols    (COLS)
    ) dut (
        .UserCLK     (UserCLK),
        .resetn      (resetn),
        .s_if        (sif.slave),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .error       (error),
        .frames_done (frames_done)
    );

    always #5 UserCLK = ~UserCLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;          // index of the next rising edge
    int acc_edge = 0;        // edge that accepted the most recent word
    int strobe_cnt = 0;
    int strobe_idx = -1;
    int strobe_edge = -1;
    int bad_onehot = 0;
    int bad_ready = 0;
    int bad_fd_hold = 0;
    int exp_done = 0;
    logic           prev_strobe = 1'b0;
    logic [FDW-1:0] prev_fd = '0;

    always @(posedge UserCLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [FDW-1:0] got, input logic [FDW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: sampled mid-cycle.
    always @(negedge UserCLK) begin
        if (FrameStrobe != '0) begin
            strobe_cnt++;
            strobe_edge = cyc - 1;
            for (int i = 0; i < STRW; i++) if (FrameStrobe[i]) strobe_idx = i;
            if ($countones(FrameStrobe) != 1) bad_onehot++;
        end
        if (sif.in_ready == (FrameStrobe != '0)) bad_ready++;
        if (prev_strobe && (FrameData != prev_fd)) bad_fd_hold++;
        prev_strobe = (FrameStrobe != '0);
        prev_fd     = FrameData;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Presents one word after `gap` idle cycles; returns at the negedge
    // following the accepting edge.
    task automatic send_word(input logic [31:0] w, input int gap);
        int n;
        sif.in_valid = 1'b0;
        repeat (gap) @(negedge UserCLK);
        sif.in_valid = 1'b1;
        sif.in_data  = w;
        n = 0;
        while (sif.in_ready !== 1'b1 && n < 50) begin
            @(negedge UserCLK);
            n++;
        end
        check_val("ready_wait", FDW'(sif.in_ready), FDW'(1'b1));
        @(posedge UserCLK);
        acc_edge = cyc;
        @(negedge UserCLK);
        sif.in_valid = 1'b0;
    endtask

    // Sends header + data (+ checksum) starting from HEADER and checks the
    // outcome one cycle after the final word.
    task automatic run_frame(input logic [7:0] fr, input logic [7:0] col, input bit directed,
                             input int max_gap, input bit flip_ck, output int hdr_edge,
                             output int last_edge);
        logic [31:0]    w;
        logic [31:0]    ck;
        logic [FDW-1:0] exp_fd;
        int             s0;
        s0 = strobe_cnt;
        ck = '0;
        exp_fd = '0;
        send_word(directed ? {fr, col, 16'h0} : {fr, col, 16'($urandom)}, 0);
        hdr_edge = acc_edge;
        for (int i = 0; i < ROWS; i++) begin
            w = directed ? 32'h100 + 32'(i) : $urandom;
            exp_fd[32*i +: 32] = w;
            ck = ck ^ w;
            send_word(w, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
        last_edge = acc_edge;
`ifdef CFG_CHECKSUM_EN
        send_word(flip_ck ? (ck ^ (32'h1 << $urandom_range(0, 31))) : ck, 0);
        last_edge = acc_edge;
`endif
        @(negedge UserCLK);
        if (!flip_ck) begin
            exp_done = (exp_done + 1) % 65536;
            check_val("strobe_count", FDW'(strobe_cnt - s0), FDW'(1));
            check_val("strobe_index", FDW'(strobe_idx), FDW'(int'(col) * FPC + int'(fr)));
            check_val("strobe_edge", FDW'(strobe_edge), FDW'(last_edge));
            check_val("frame_data", FrameData, exp_fd);
            check_val("frames_done", FDW'(frames_done), FDW'(exp_done));
            check_val("busy_header", FDW'(busy), FDW'(1'b1));
        end else begin
            check_val("ck_no_strobe", FDW'(strobe_cnt - s0), FDW'(0));
            check_val("ck_error", FDW'(error), FDW'(1'b1));
            check_val("ck_idle", FDW'(busy), FDW'(1'b0));
            check_val("ck_done_kept", FDW'(frames_done), FDW'(exp_done));
        end
    endtask

    initial begin
        int he, le, he2, le2, s0;
        logic [31:0] w;
        sif.in_valid = 1'b0;
        sif.in_data  = '0;

        // Reset
        resetn = 1'b0;
        repeat (3) @(negedge UserCLK);
        check_val("rst_ready", FDW'(sif.in_ready), FDW'(1'b1));
        check_val("rst_busy", FDW'(busy), FDW'(1'b0));
        check_val("rst_error", FDW'(error), FDW'(1'b0));
        check_val("rst_done", FDW'(frames_done), FDW'(0));
        check_val("rst_fd", FrameData, '0);
        check_val("rst_strobe", FDW'(FrameStrobe), FDW'(0));
        resetn = 1'b1;
        @(negedge UserCLK);

        // Directed frame 3 / col 5
        send_word(SYNC_WORD, 0);
        check_val("sync_busy", FDW'(busy), FDW'(1'b1));
        run_frame(8'd3, 8'd5, 1'b1, 0, 1'b0, he, le);
        $display("frame fr=3 col=5 strobe_idx=%0d done=%0d", strobe_idx, frames_done);

        // Bad frame index
        s0 = strobe_cnt;
        send_word(32'h1400_0000, 0);
        check_val("badfr_error", FDW'(error), FDW'(1'b1));
        check_val("badfr_idle", FDW'(busy), FDW'(1'b0));
        send_word(SYNC_WORD, 0);
        check_val("sync_clears_err", FDW'(error), FDW'(1'b0));
        // Bad column index
        send_word({8'($urandom_range(0, FPC - 1)), 8'($urandom_range(COLS, 255)), 16'h0}, 0);
        check_val("badcol_error", FDW'(error), FDW'(1'b1));
        check_val("badcol_idle", FDW'(busy), FDW'(1'b0));
        check_val("bad_no_strobe", FDW'(strobe_cnt - s0), FDW'(0));
        send_word(SYNC_WORD, 0);
        // SYNC in HEADER stays, DESYNC leaves
        send_word(SYNC_WORD, 0);
        check_val("sync_in_hdr", FDW'(busy), FDW'(1'b1));
        send_word(DESYNC_WORD, 0);
        check_val("desync_idle", FDW'(busy), FDW'(1'b0));
        send_word(SYNC_WORD, 0);

        // Random frames with random valid gaps
        for (int k = 0; k < 6; k++) begin
            logic [7:0] fr, col;
            fr  = 8'($urandom_range(0, FPC - 1));
            col = 8'($urandom_range(0, COLS - 1));
            run_frame(fr, col, 1'b0, 3, 1'b0, he, le);
            $display("frame fr=%0d col=%0d strobe_idx=%0d done=%0d", fr, col, strobe_idx, frames_done);
        end

        // Back-to-back corner addresses
        run_frame(8'd0, 8'd0, 1'b0, 0, 1'b0, he, le);
        run_frame(8'd19, 8'd15, 1'b0, 0, 1'b0, he2, le2);
        check_val("b2b_hdr_edge", FDW'(he2), FDW'(le + 2));
        $display("b2b last_edge=%0d next_hdr_edge=%0d", le, he2);

        // Reset in the middle of DATA
        send_word({8'd2, 8'd1, 16'h0}, 0);
        for (int i = 0; i < 7; i++) send_word($urandom, 0);
        resetn = 1'b0;
        @(negedge UserCLK);
        check_val("mid_rst_fd", FrameData, '0);
        check_val("mid_rst_strobe", FDW'(FrameStrobe), FDW'(0));
        check_val("mid_rst_done", FDW'(frames_done), FDW'(0));
        check_val("mid_rst_busy", FDW'(busy), FDW'(1'b0));
        check_val("mid_rst_ready", FDW'(sif.in_ready), FDW'(1'b1));
        exp_done = 0;
        resetn = 1'b1;
        s0 = strobe_cnt;
        for (int i = 0; i < 10; i++) begin
            w = $urandom;
            if (w == SYNC_WORD) w = ~w;
            send_word(w, 0);
        end
        check_val("junk_idle", FDW'(busy), FDW'(1'b0));
        check_val("junk_no_strobe", FDW'(strobe_cnt - s0), FDW'(0));
        send_word(SYNC_WORD, 0);
        run_frame(8'($urandom_range(0, FPC - 1)), 8'($urandom_range(0, COLS - 1)), 1'b0, 2, 1'b0, he, le);

`ifdef CFG_CHECKSUM_EN
        run_frame(8'd7, 8'd9, 1'b0, 1, 1'b1, he, le);
        $display("checksum flip error=%0d", error);
        send_word(SYNC_WORD, 0);
        run_frame(8'd7, 8'd9, 1'b0, 1, 1'b0, he, le);
`endif

        repeat (3) @(negedge UserCLK);
        check_val("onehot", FDW'(bad_onehot), FDW'(0));
        check_val("ready_vs_strobe", FDW'(bad_ready), FDW'(0));
        check_val("fd_hold_in_strobe", FDW'(bad_fd_hold), FDW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
